gf_table_gen: RTL and testbench



---
 rtl/gf_table_gen.sv | 149 ++++++++++++++
 tb/tb_gf_table_gen.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf_table_gen.sv
// gf_table_gen: builds the GF(2^M) exponent (alpha^i) table, and optionally the
// log table, by stepping a Galois LFSR over POLY after reset or reinit. Once
// built it serves one-cycle registered lookups and reports a non-primitive POLY.
// Optional feature macro: GF_LOG_TABLE_EN (log table and req_mode lookup).
module gf_table_gen #(
  parameter int unsigned M    = 8,
  parameter int unsigned POLY = 'h11D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         reinit,
  output logic         ready,
  output logic         poly_err,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_mode,
  input  logic [M-1:0] req_addr,
  output logic         resp_valid,
  output logic [M-1:0] resp_data,
  output logic         dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready
  // are both high. req_ready depends only on ready and reinit, never on
  // req_valid. Every transferred request yields exactly one resp_valid cycle
  // right after the transfer edge; there is no backpressure on responses.

  localparam int unsigned   N         = 1 << M;
  localparam logic [M-1:0]  ONE       = {{(M-1){1'b0}}, 1'b1};
  localparam logic [M-1:0]  LAST      = '1;          // 2^M-1: sentinel slot
  localparam logic [M-1:0]  LAST_STEP = LAST - ONE;  // 2^M-2: last LFSR step
  localparam logic [M-1:0]  POLY_TAPS = POLY[M-1:0];

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t       state;
  logic [M-1:0] idx;
  logic [M-1:0] lfsr;
  logic [M-1:0] lfsr_next;
  logic         is_last;
  logic         fill_we;
  logic [M-1:0] exp_wdata;
  logic         accept;
  logic [M-1:0] rd_data;

  logic [M-1:0] exp_mem [N];

`ifdef GF_LOG_TABLE_EN
  logic [M-1:0] log_mem [N];
  logic [M-1:0] log_waddr;
`else
  logic         unused_req_mode;
  assign unused_req_mode = req_mode;
`endif

  assign dbg_state = (state == ST_DONE);
  assign req_ready = ready && !reinit;
  assign accept    = req_valid && req_ready;
  assign is_last   = (idx == LAST);
  assign fill_we   = (state == ST_FILL) && !reinit;

  // Next LFSR value: multiply the current element by alpha modulo POLY.
  always_comb begin
    lfsr_next = {lfsr[M-2:0], 1'b0} ^ (lfsr[M-1] ? POLY_TAPS : '0);
  end

  // Table write data: LFSR element per step, sentinels in the final slot.
  always_comb begin
    exp_wdata = is_last ? '0 : lfsr;
`ifdef GF_LOG_TABLE_EN
    log_waddr = is_last ? '0 : lfsr;
`endif
  end

  // Fill sequencer: walks idx through every slot, tracks primitivity, raises ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FILL;
      idx      <= '0;
      lfsr     <= ONE;
      poly_err <= 1'b0;
      ready    <= 1'b0;
    end else if (reinit) begin
      state    <= ST_FILL;
      idx      <= '0;
      lfsr     <= ONE;
      poly_err <= 1'b0;
      ready    <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          if (is_last) begin
            state <= ST_DONE;
            ready <= 1'b1;
          end else begin
            lfsr <= lfsr_next;
            idx  <= idx + ONE;
            // alpha must return to 1 exactly after 2^M-1 steps, never sooner
            if (idx == LAST_STEP) begin
              if (lfsr_next != ONE) poly_err <= 1'b1;
            end else if (lfsr_next == ONE) begin
              poly_err <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          ready <= 1'b1;
        end
        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

  // Table storage: written only while filling, so lookups never collide.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      exp_mem[idx] <= exp_wdata;
`ifdef GF_LOG_TABLE_EN
      log_mem[log_waddr] <= idx;
`endif
    end
  end

  // Lookup read mux: log table only exists when the feature is built.
  always_comb begin
`ifdef GF_LOG_TABLE_EN
    rd_data = req_mode ? log_mem[req_addr] : exp_mem[req_addr];
`else
    rd_data = exp_mem[req_addr];
`endif
  end

  // Response register: one strobe per accepted request, data held between.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      resp_valid <= accept;
      if (accept) resp_data <= rd_data;
    end
  end

endmodule

// File: tb/tb_gf_table_gen.sv
// tb_gf_table_gen: exercises gf_table_gen at M=8/POLY='h11D plus two M=4 fields
// (one non-primitive) against a polynomial-arithmetic reference model.
module tb_gf_table_gen;

`ifdef GF_LOG_TABLE_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic reinit = 1'b0;
  logic small_reinit = 1'b0;
  always #5 clk = ~clk;

  // M=8 instance
  logic       a_ready, a_poly_err, a_dbg;
  logic       req_valid = 1'b0, req_ready, req_mode = 1'b0;
  logic [7:0] req_addr = '0;
  logic       resp_valid;
  logic [7:0] resp_data;

  // M=4 non-primitive (POLY='h1F) and primitive (POLY='h13) instances
  logic       b_ready, b_poly_err, b_dbg, b_req_valid = 1'b0, b_req_ready, b_req_mode = 1'b0;
  logic [3:0] b_req_addr = '0, b_resp_data;
  logic       b_resp_valid;
  logic       c_ready, c_poly_err, c_dbg, c_req_valid = 1'b0, c_req_ready, c_req_mode = 1'b0;
  logic [3:0] c_req_addr = '0, c_resp_data;
  logic       c_resp_valid;

  gf_table_gen #(.M(8), .POLY('h11D)) u_dut (
    .clk(clk), .rst(rst), .reinit(reinit), .ready(a_ready), .poly_err(a_poly_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .dbg_state(a_dbg)
  );

  gf_table_gen #(.M(4), .POLY('h1F)) u_dut_b (
    .clk(clk), .rst(rst), .reinit(small_reinit), .ready(b_ready), .poly_err(b_poly_err),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_mode(b_req_mode), .req_addr(b_req_addr),
    .resp_valid(b_resp_valid), .resp_data(b_resp_data), .dbg_state(b_dbg)
  );

  gf_table_gen #(.M(4), .POLY('h13)) u_dut_c (
    .clk(clk), .rst(rst), .reinit(small_reinit), .ready(c_ready), .poly_err(c_poly_err),
    .req_valid(c_req_valid), .req_ready(c_req_ready), .req_mode(c_req_mode), .req_addr(c_req_addr),
    .resp_valid(c_resp_valid), .resp_data(c_resp_data), .dbg_state(c_dbg)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  int exp8[256];
  int log8[256];
  int expb[16];
  int expc[16];
  bit prim8, primb, primc;
  logic [7:0] exp_q[$];

  // polynomial product of a and b reduced modulo poly (poly includes x^m)
  function automatic int gf_mul(int a, int b, int m, int poly);
    int p = 0;
    for (int i = 0; i < m; i++) if (((b >> i) & 1) == 1) p = p ^ (a << i);
    for (int i = 2 * m - 2; i >= m; i--) if (((p >> i) & 1) == 1) p = p ^ (poly << (i - m));
    return p;
  endfunction

  // alpha^e by square-and-multiply, alpha = x
  function automatic int gf_pow(int e, int m, int poly);
    int r = 1;
    int b = 2;
    for (int i = 0; i < 16; i++) begin
      if (((e >> i) & 1) == 1) r = gf_mul(r, b, m, poly);
      b = gf_mul(b, b, m, poly);
    end
    return r;
  endfunction

  // primitive iff the multiplicative order of alpha is exactly 2^m-1
  function automatic bit is_primitive(int m, int poly);
    int n = (1 << m) - 1;
    for (int k = 1; k < n; k++) if (gf_pow(k, m, poly) == 1) return 1'b0;
    return gf_pow(n, m, poly) == 1;
  endfunction

  task automatic build_model();
    for (int i = 0; i < 255; i++) exp8[i] = gf_pow(i, 8, 'h11D);
    exp8[255] = 0;
    for (int i = 0; i < 255; i++) log8[exp8[i]] = i;
    log8[0] = 255;
    for (int i = 0; i < 15; i++) begin
      expb[i] = gf_pow(i, 4, 'h1F);
      expc[i] = gf_pow(i, 4, 'h13);
    end
    expb[15] = 0;
    expc[15] = 0;
    prim8 = is_primitive(8, 'h11D);
    primb = is_primitive(4, 'h1F);
    primc = is_primitive(4, 'h13);
  endtask

  // ---------------- driver ----------------
  task automatic lookup(input logic mode, input logic [7:0] addr,
                        output logic v, output logic [7:0] d);
    req_valid = 1'b1;
    req_mode  = mode;
    req_addr  = addr;
    @(posedge clk); #1;
    v = resp_valid;
    d = resp_data;
    req_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b want=0", a_ready); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%0b want=0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%0b want=0", resp_valid); end
    checks++; if (resp_data !== 8'h00) begin failures++; $display("FAIL reset_resp_data got=%0h want=0", resp_data); end
    checks++; if (a_poly_err !== 1'b0) begin failures++; $display("FAIL reset_poly_err got=%0b want=0", a_poly_err); end
    checks++; if (a_dbg !== 1'b0) begin failures++; $display("FAIL reset_state got=%0b want=0", a_dbg); end
    checks++; if (b_ready !== 1'b0 || c_ready !== 1'b0) begin failures++; $display("FAIL reset_small_ready got=%0b%0b want=00", b_ready, c_ready); end
  endtask

  task automatic test_build();
    int n = 0, nb = 0, nc = 0;
    rst = 1'b0;
    while (a_ready !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (b_ready === 1'b1 && nb == 0) nb = n;
      if (c_ready === 1'b1 && nc == 0) nc = n;
    end
    checks++; if (n != 256) begin failures++; $display("FAIL build_edges_m8 got=%0d want=256", n); end
    checks++; if (nb != 16) begin failures++; $display("FAIL build_edges_m4_1f got=%0d want=16", nb); end
    checks++; if (nc != 16) begin failures++; $display("FAIL build_edges_m4_13 got=%0d want=16", nc); end
    checks++; if (a_poly_err !== ~prim8) begin failures++; $display("FAIL poly_err_11d got=%0b want=%0b", a_poly_err, ~prim8); end
    checks++; if (b_poly_err !== ~primb) begin failures++; $display("FAIL poly_err_1f got=%0b want=%0b", b_poly_err, ~primb); end
    checks++; if (c_poly_err !== ~primc) begin failures++; $display("FAIL poly_err_13 got=%0b want=%0b", c_poly_err, ~primc); end
    checks++; if (a_dbg !== 1'b1) begin failures++; $display("FAIL build_state got=%0b want=1", a_dbg); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL build_req_ready got=%0b want=1", req_ready); end
  endtask

  logic [7:0] pts_addr[6] = '{8'd0, 8'd8, 8'd12, 8'd25, 8'd254, 8'd255};
  logic [7:0] pts_want[6] = '{8'h01, 8'h1D, 8'hCD, 8'h03, 8'h8E, 8'h00};

  task automatic test_exp_points();
    logic v;
    logic [7:0] d;
    for (int i = 0; i < 6; i++) begin
      lookup(1'b0, pts_addr[i], v, d);
      checks++; if (v !== 1'b1) begin failures++; $display("FAIL exp_pt_valid addr=%0d got=%0b want=1", pts_addr[i], v); end
      checks++; if (d !== pts_want[i]) begin failures++; $display("FAIL exp_pt addr=%0d got=%0h want=%0h", pts_addr[i], d, pts_want[i]); end
      checks++; if (d !== 8'(exp8[pts_addr[i]])) begin failures++; $display("FAIL exp_pt_model addr=%0d got=%0h want=%0h", pts_addr[i], d, exp8[pts_addr[i]]); end
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL exp_pt_single_pulse got=%0b want=0", resp_valid); end
    end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1;
    req_mode  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      req_addr = 8'(i);
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 8'(exp8[i])) begin
        failures++;
        $display("FAIL b2b_sweep addr=%0d got=%0b/%0h want=1/%0h", i, resp_valid, resp_data, exp8[i]);
      end
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_tail got=%0b want=0", resp_valid); end
  endtask

`ifdef GF_LOG_TABLE_EN
  logic [7:0] log_elem[5] = '{8'h1D, 8'h03, 8'h01, 8'h8E, 8'h00};
  logic [7:0] log_want[5] = '{8'd8, 8'd25, 8'd0, 8'd254, 8'hFF};

  task automatic test_log();
    logic v;
    logic [7:0] d, l;
    for (int i = 0; i < 5; i++) begin
      lookup(1'b1, log_elem[i], v, d);
      checks++; if (v !== 1'b1 || d !== log_want[i]) begin failures++; $display("FAIL log_pt elem=%0h got=%0b/%0d want=1/%0d", log_elem[i], v, d, log_want[i]); end
    end
    for (int x = 1; x < 256; x++) begin
      lookup(1'b1, 8'(x), v, l);
      checks++; if (l !== 8'(log8[x])) begin failures++; $display("FAIL log_model elem=%0h got=%0d want=%0d", x, l, log8[x]); end
      lookup(1'b0, l, v, d);
      checks++; if (d !== 8'(x)) begin failures++; $display("FAIL exp_of_log elem=%0h got=%0h want=%0h", x, d, x); end
    end
  endtask
`else
  task automatic test_mode_ignored();
    logic v;
    logic [7:0] d, a;
    for (int i = 0; i < 32; i++) begin
      a = 8'($urandom_range(0, 255));
      lookup(1'b1, a, v, d);
      checks++; if (v !== 1'b1 || d !== 8'(exp8[a])) begin failures++; $display("FAIL mode_ignored addr=%0d got=%0b/%0h want=1/%0h", a, v, d, exp8[a]); end
    end
  endtask
`endif

  // random valid/mode/addr stream scored through an expected queue
  task automatic test_random(input int cycles);
    logic [7:0] e;
    exp_q.delete();
    for (int i = 0; i < cycles; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_mode  = 1'($urandom_range(0, 1));
      req_addr  = 8'($urandom_range(0, 255));
      if (req_valid) exp_q.push_back((req_mode && LOG_EN) ? 8'(log8[req_addr]) : 8'(exp8[req_addr]));
      @(posedge clk); #1;
      checks++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (resp_valid !== 1'b1 || resp_data !== e) begin
          failures++;
          $display("FAIL random_resp cycle=%0d got=%0b/%0h want=1/%0h", i, resp_valid, resp_data, e);
        end
      end else if (resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL random_idle cycle=%0d got=%0b want=0", i, resp_valid);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_small_fields();
    c_req_valid = 1'b1;
    c_req_addr  = 4'd4;
    @(posedge clk); #1;
    checks++; if (c_resp_valid !== 1'b1 || c_resp_data !== 4'h3) begin failures++; $display("FAIL m4_13_exp4 got=%0b/%0h want=1/3", c_resp_valid, c_resp_data); end
    b_req_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b_req_addr = 4'(i);
      c_req_addr = 4'(i);
      b_req_mode = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      checks++; if (c_resp_valid !== 1'b1 || c_resp_data !== 4'(expc[i])) begin failures++; $display("FAIL m4_13_sweep addr=%0d got=%0b/%0h want=1/%0h", i, c_resp_valid, c_resp_data, expc[i]); end
      if (b_req_mode == 1'b0 || !LOG_EN) begin
        checks++; if (b_resp_valid !== 1'b1 || b_resp_data !== 4'(expb[i])) begin failures++; $display("FAIL m4_1f_sweep addr=%0d got=%0b/%0h want=1/%0h", i, b_resp_valid, b_resp_data, expb[i]); end
      end
    end
    b_req_valid = 1'b0;
    c_req_valid = 1'b0;
  endtask

  task automatic test_reinit();
    int n = 0;
    bit bad = 1'b0;
    req_valid = 1'b1;
    req_mode  = 1'b0;
    req_addr  = 8'd25;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b1 || resp_data !== 8'h03) begin failures++; $display("FAIL reinit_prior_resp got=%0b/%0h want=1/03", resp_valid, resp_data); end
    reinit = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reinit_req_ready got=%0b want=0", req_ready); end
    @(posedge clk); #1;
    reinit = 1'b0;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reinit_same_cycle_req got=%0b want=0", resp_valid); end
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL reinit_ready_drop got=%0b want=0", a_ready); end
    repeat (100) begin
      @(posedge clk); #1;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0) bad = 1'b1;
    end
    reinit = 1'b1;
    @(posedge clk); #1;
    reinit   = 1'b0;
    req_addr = 8'd12;
    while (a_ready !== 1'b1 && n < 1000) begin
      if (req_ready !== 1'b0 || resp_valid !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    checks++; if (bad) begin failures++; $display("FAIL reinit_quiet got=activity want=none"); end
    checks++; if (n != 256) begin failures++; $display("FAIL reinit_rebuild_edges got=%0d want=256", n); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_data !== 8'hCD) begin failures++; $display("FAIL reinit_exp12 got=%0b/%0h want=1/cd", resp_valid, resp_data); end
  endtask

  task automatic test_async_reset();
    int n = 0;
    req_valid = 1'b1;
    req_mode  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_addr = (i == 4) ? 8'd12 : 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    checks++; if (resp_valid !== 1'b1 || resp_data !== 8'hCD) begin failures++; $display("FAIL arst_prestream got=%0b/%0h want=1/cd", resp_valid, resp_data); end
    #2;
    rst = 1'b1;
    #1;
    req_valid = 1'b0;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL arst_resp_valid got=%0b want=0", resp_valid); end
    checks++; if (resp_data !== 8'h00) begin failures++; $display("FAIL arst_resp_data got=%0h want=0", resp_data); end
    checks++; if (a_ready !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL arst_ready got=%0b%0b want=00", a_ready, req_ready); end
    checks++; if (b_poly_err !== 1'b0) begin failures++; $display("FAIL arst_poly_err got=%0b want=0", b_poly_err); end
    checks++; if (a_dbg !== 1'b0) begin failures++; $display("FAIL arst_state got=%0b want=0", a_dbg); end
    @(posedge clk); #1;
    rst = 1'b0;
    while (a_ready !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n != 256) begin failures++; $display("FAIL arst_rebuild_edges got=%0d want=256", n); end
    checks++; if (b_poly_err !== ~primb) begin failures++; $display("FAIL arst_poly_err_again got=%0b want=%0b", b_poly_err, ~primb); end
    test_random(150);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    build_model();
    test_reset();
    test_build();
    test_exp_points();
    test_back_to_back();
`ifdef GF_LOG_TABLE_EN
    test_log();
`else
    test_mode_ignored();
`endif
    test_random(300);
    test_small_fields();
    test_reinit();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
